pacman_sprite_fetch: RTL

//  Downstream consumer of the Pac-Man sprite RAM (52x52, 24-bit RGB, 2704 words, 1-cycle sync read).

---
 rtl/pacman_sprite_fetch.sv | 74 +++++++
 1 files changed

// File: rtl/pacman_sprite_fetch.sv
// pacman_sprite_fetch: sprite RAM address generation, orientation and 3-stage pixel realignment for the Pac-Man sprite
module pacman_sprite_fetch #(
  parameter int SPR_W = 52,
  parameter int SPR_H = 52,
  parameter int ADDR_W = 12,
  parameter int COLOR_W = 24,
  parameter logic [COLOR_W-1:0] KEY_COLOR = '0
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_start,
  input  logic [9:0]         pac_x,
  input  logic [9:0]         pac_y,
  input  logic [1:0]         pac_dir,
  input  logic               pixel_valid,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  output logic [ADDR_W-1:0]  read_address,
  input  logic [COLOR_W-1:0] ram_data,
  output logic               pix_valid,
  output logic               pix_hit,
  output logic [COLOR_W-1:0] pix_rgb
);
  localparam int CW = $clog2(SPR_W > SPR_H ? SPR_W : SPR_H);
  logic [9:0] r_px, r_py;
  logic [1:0] r_dir;
  logic r_v1, r_b1, r_v2, r_b2;
  logic [10:0] w_dx, w_dy;
  logic [CW-1:0] w_fx, w_fy, w_row, w_col;
  logic w_in_box, w_opaque;
  logic [ADDR_W-1:0] w_addr;
  assign w_dx = {1'b0, DrawX} - {1'b0, r_px};
  assign w_dy = {1'b0, DrawY} - {1'b0, r_py};
  // a negative offset borrows into a huge 11-bit value, so one compare covers both box edges
  assign w_in_box = pixel_valid & (w_dx < 11'(SPR_W)) & (w_dy < 11'(SPR_H));
  assign w_fx = CW'(SPR_W - 1) - w_dx[CW-1:0];
  assign w_fy = CW'(SPR_H - 1) - w_dy[CW-1:0];
  assign w_row = r_dir[1] ? (r_dir[0] ? w_fx : w_dx[CW-1:0]) : w_dy[CW-1:0];
  assign w_col = r_dir[1] ? (r_dir[0] ? w_dy[CW-1:0] : w_fy) : (r_dir[0] ? w_fx : w_dx[CW-1:0]);
  assign w_addr = ADDR_W'(w_row) * ADDR_W'(SPR_W) + ADDR_W'(w_col);
  assign w_opaque = ram_data != KEY_COLOR;
  // position latch once per frame, so the sprite never tears mid-frame
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      r_px <= '0;
      r_py <= '0;
      r_dir <= '0;
    end else if (frame_start) begin
      r_px <= pac_x;
      r_py <= pac_y;
      r_dir <= pac_dir;
    end
  // address stage, then RAM wait stage, then keyed colour output stage
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      read_address <= '0;
      r_v1 <= 1'b0;
      r_b1 <= 1'b0;
      r_v2 <= 1'b0;
      r_b2 <= 1'b0;
      pix_valid <= 1'b0;
      pix_hit <= 1'b0;
      pix_rgb <= '0;
    end else begin
      read_address <= w_in_box ? w_addr : '0;
      r_v1 <= pixel_valid;
      r_b1 <= w_in_box;
      r_v2 <= r_v1;
      r_b2 <= r_b1;
      pix_valid <= r_v2;
      pix_hit <= r_b2 & w_opaque;
      pix_rgb <= (r_b2 & w_opaque) ? ram_data : '0;
    end
endmodule
